// File: rtl/thread_regfile.sv
// Per-thread register file for one SIMT lane: 13 writable GPRs plus read-only
// %blockIdx/%blockDim/%threadIdx, read in REQUEST and written back in UPDATE.
module thread_regfile #(
  parameter int DATA_BITS         = 16,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] block_id,
  input  logic [2:0]           core_state,
  input  logic [3:0]           decoded_rd_address,
  input  logic [3:0]           decoded_rs_address,
  input  logic [3:0]           decoded_rt_address,
  input  logic                 decoded_reg_write_enable,
  input  logic [1:0]           decoded_reg_input_mux,
  input  logic [7:0]           decoded_immediate,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  input  logic [DATA_BITS-1:0] fma_out,
  output logic [DATA_BITS-1:0] rs,
  output logic [DATA_BITS-1:0] rt
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_FETCH   = 3'b001,
    ST_DECODE  = 3'b010,
    ST_REQUEST = 3'b011,
    ST_WAIT    = 3'b100,
    ST_EXECUTE = 3'b101,
    ST_UPDATE  = 3'b110,
    ST_DONE    = 3'b111
  } core_state_t;

  localparam int NUM_GPR = 13;
  localparam logic [1:0] MUX_ALU = 2'b00;
  localparam logic [1:0] MUX_LSU = 2'b01;
  localparam logic [1:0] MUX_IMM = 2'b10;
  localparam logic [1:0] MUX_FMA = 2'b11;

  core_state_t          w_state;
  logic                 w_do_idle;
  logic                 w_do_request;
  logic                 w_do_update;
  logic [DATA_BITS-1:0] w_wr_data;
  logic [DATA_BITS-1:0] w_file [16];
  logic [DATA_BITS-1:0] r_block_idx;

  assign w_state      = core_state_t'(core_state);
  assign w_do_idle    = enable && (w_state == ST_IDLE);
  assign w_do_request = enable && (w_state == ST_REQUEST);
  // Writes aimed at R13-R15 fall outside every GPR's decode and vanish here.
  assign w_do_update  = enable && (w_state == ST_UPDATE) && decoded_reg_write_enable;

  always_comb begin
    w_wr_data = alu_out;
    case (decoded_reg_input_mux)
      MUX_ALU: w_wr_data = alu_out;
      MUX_LSU: w_wr_data = lsu_out;
      MUX_IMM: w_wr_data = {{(DATA_BITS-8){1'b0}}, decoded_immediate};
      MUX_FMA: w_wr_data = fma_out;
      default: w_wr_data = alu_out;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_GPR; gi++) begin : gen_gpr
      logic                 w_wr_sel;
      logic [DATA_BITS-1:0] r_val;

      assign w_wr_sel = w_do_update && (decoded_rd_address == 4'(gi));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_val <= '0;
        end else if (w_wr_sel) begin
          r_val <= w_wr_data;
        end
      end

      assign w_file[gi] = r_val;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_block_idx <= '0;
    end else if (w_do_idle) begin
      r_block_idx <= block_id;
    end
  end

  // %blockDim and %threadIdx never change, so they need no storage.
  assign w_file[13] = r_block_idx;
  assign w_file[14] = DATA_BITS'(THREADS_PER_BLOCK);
  assign w_file[15] = DATA_BITS'(THREAD_ID);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs <= '0;
      rt <= '0;
    end else if (w_do_request) begin
      rs <= w_file[decoded_rs_address];
      rt <= w_file[decoded_rt_address];
    end
  end

endmodule

// File: tb/tb_thread_regfile.sv
// Directed, table-driven bench for thread_regfile with a few hand-written
// sequences for asynchronous reset corner cases.
`timescale 1ns/1ps
module tb_thread_regfile;

  localparam int DW = 16;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_REQ  = 3'b011;
  localparam logic [2:0] S_WAIT = 3'b100;
  localparam logic [2:0] S_EXE  = 3'b101;
  localparam logic [2:0] S_UPD  = 3'b110;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [DW-1:0] block_id;
  logic [2:0]    core_state;
  logic [3:0]    rd_a, rs_a, rt_a;
  logic          we;
  logic [1:0]    mux;
  logic [7:0]    imm;
  logic [DW-1:0] alu_out, lsu_out, fma_out;
  logic [DW-1:0] rs, rt;

  int n_vec  = 0;
  int n_fail = 0;

  thread_regfile #(.DATA_BITS(DW), .THREADS_PER_BLOCK(4), .THREAD_ID(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .block_id(block_id),
    .core_state(core_state), .decoded_rd_address(rd_a),
    .decoded_rs_address(rs_a), .decoded_rt_address(rt_a),
    .decoded_reg_write_enable(we), .decoded_reg_input_mux(mux),
    .decoded_immediate(imm), .alu_out(alu_out), .lsu_out(lsu_out),
    .fma_out(fma_out), .rs(rs), .rt(rt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    st;
    logic          en;
    logic [DW-1:0] bid;
    logic [3:0]    rd, ra, rb;
    logic          we;
    logic [1:0]    mux;
    logic [7:0]    imm;
    logic [DW-1:0] data;  // driven onto alu/lsu/fma alike
    logic          chk;
    logic [DW-1:0] exp_rs, exp_rt;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(logic [2:0] st, logic en, logic [DW-1:0] bid,
                              logic [3:0] rd, logic [3:0] ra, logic [3:0] rb,
                              logic w, logic [1:0] m, logic [7:0] im,
                              logic [DW-1:0] d, logic c,
                              logic [DW-1:0] ers, logic [DW-1:0] ert);
    vec_t v;
    v.st = st; v.en = en; v.bid = bid; v.rd = rd; v.ra = ra; v.rb = rb;
    v.we = w; v.mux = m; v.imm = im; v.data = d; v.chk = c;
    v.exp_rs = ers; v.exp_rt = ert;
    return v;
  endfunction

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%04h", name, act);
    end
  endtask

  task automatic drive(vec_t v);
    core_state = v.st; enable = v.en; block_id = v.bid;
    rd_a = v.rd; rs_a = v.ra; rt_a = v.rb; we = v.we; mux = v.mux; imm = v.imm;
    alu_out = v.data; lsu_out = v.data; fma_out = v.data;
  endtask

  initial begin
    // state, en, block_id, rd, rs, rt, we, mux, imm, data, chk, exp_rs, exp_rt
    tbl[0]  = mk(S_IDLE, 1, 16'd7,  0,  0,  0, 0, 2'b00, 8'h00, 16'h0000, 0, 0, 0);
    tbl[1]  = mk(S_REQ,  1, 16'd7,  0, 14, 15, 0, 2'b00, 8'h00, 16'h0000, 1, 16'd4, 16'd2);
    tbl[2]  = mk(S_UPD,  1, 16'd7,  3,  0,  0, 1, 2'b00, 8'h00, 16'h1234, 0, 0, 0);
    tbl[3]  = mk(S_REQ,  1, 16'd7,  0,  3, 13, 0, 2'b00, 8'h00, 16'h0000, 1, 16'h1234, 16'd7);
    tbl[4]  = mk(S_UPD,  1, 16'd7,  5,  0,  0, 1, 2'b10, 8'hAB, 16'hFFFF, 0, 0, 0);
    tbl[5]  = mk(S_UPD,  1, 16'd7,  6,  0,  0, 1, 2'b11, 8'h00, 16'h8000, 0, 0, 0);
    tbl[6]  = mk(S_REQ,  1, 16'd7,  0,  5,  6, 0, 2'b00, 8'h00, 16'h0000, 1, 16'h00AB, 16'h8000);
    tbl[7]  = mk(S_UPD,  1, 16'd7, 15,  0,  0, 1, 2'b00, 8'h00, 16'hFFFF, 0, 0, 0);
    tbl[8]  = mk(S_UPD,  1, 16'd7, 13,  0,  0, 1, 2'b00, 8'h00, 16'hFFFF, 0, 0, 0);
    tbl[9]  = mk(S_REQ,  1, 16'd7,  0, 15, 13, 0, 2'b00, 8'h00, 16'h0000, 1, 16'd2, 16'd7);
    tbl[10] = mk(S_UPD,  0, 16'd7,  1,  0,  0, 1, 2'b01, 8'h00, 16'h0055, 0, 0, 0);
    tbl[11] = mk(S_REQ,  1, 16'd7,  0,  1,  0, 0, 2'b00, 8'h00, 16'h0000, 1, 16'h0000, 16'h0000);
    tbl[12] = mk(S_UPD,  1, 16'd7,  1,  0,  0, 1, 2'b01, 8'h00, 16'h0F0F, 0, 0, 0);
    tbl[13] = mk(S_REQ,  1, 16'd7,  0,  1,  3, 0, 2'b00, 8'h00, 16'h0000, 1, 16'h0F0F, 16'h1234);
    tbl[14] = mk(S_REQ,  0, 16'd7,  0, 14,  5, 0, 2'b00, 8'h00, 16'h0000, 1, 16'h0F0F, 16'h1234);
    tbl[15] = mk(S_WAIT, 1, 16'd7,  0,  5,  6, 0, 2'b00, 8'h00, 16'h0000, 1, 16'h0F0F, 16'h1234);
    tbl[16] = mk(S_IDLE, 1, 16'd9,  0,  0,  0, 0, 2'b00, 8'h00, 16'h0000, 0, 0, 0);
    tbl[17] = mk(S_EXE,  1, 16'd3,  4,  0,  0, 1, 2'b00, 8'h00, 16'h4444, 0, 0, 0);
    tbl[18] = mk(S_REQ,  1, 16'd3,  0, 13,  4, 0, 2'b00, 8'h00, 16'h0000, 1, 16'd9, 16'h0000);
    tbl[19] = mk(S_IDLE, 0, 16'd11, 0,  0,  0, 0, 2'b00, 8'h00, 16'h0000, 0, 0, 0);
    tbl[20] = mk(S_UPD,  1, 16'd11, 2,  0,  0, 0, 2'b00, 8'h00, 16'hBEEF, 0, 0, 0);
    tbl[21] = mk(S_REQ,  1, 16'd11, 0, 13,  2, 0, 2'b00, 8'h00, 16'h0000, 1, 16'd9, 16'h0000);
    tbl[22] = mk(S_UPD,  1, 16'd11,12,  0,  0, 1, 2'b00, 8'h00, 16'h7777, 0, 0, 0);
    tbl[23] = mk(S_REQ,  1, 16'd11, 0, 12,  3, 0, 2'b00, 8'h00, 16'h0000, 1, 16'h7777, 16'h1234);
    tbl[24] = mk(S_DONE_F(), 1, 16'd11, 0, 0, 0, 0, 2'b00, 8'h00, 16'h0000, 1, 16'h7777, 16'h1234);

    // Reset held from time 0; outputs must already be cleared.
    reset = 1'b0;
    drive(tbl[0]);
    #2;
    check("reset_rs", rs, 16'h0000);
    check("reset_rt", rt, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      @(posedge clk);
      #1;
      if (tbl[i].chk) begin
        check($sformatf("vec%0d_rs", i), rs, tbl[i].exp_rs);
        check($sformatf("vec%0d_rt", i), rt, tbl[i].exp_rt);
      end
    end

    // Mid-cycle asynchronous reset clears the operand registers at once.
    @(negedge clk);
    drive(mk(S_UPD, 1, 16'd5, 4, 0, 0, 1, 2'b00, 8'h00, 16'h4444, 0, 0, 0));
    #2;
    reset = 1'b0;
    #1;
    check("midreset_rs", rs, 16'h0000);
    check("midreset_rt", rt, 16'h0000);
    @(posedge clk);  // UPDATE edge under reset: write must be lost
    #1;
    @(negedge clk);
    reset = 1'b1;
    drive(mk(S_REQ, 1, 16'd5, 0, 4, 13, 0, 2'b00, 8'h00, 16'h0000, 0, 0, 0));
    @(posedge clk);
    #1;
    check("post_reset_r4", rs, 16'h0000);
    check("post_reset_r13", rt, 16'h0000);
    @(negedge clk);
    drive(mk(S_REQ, 1, 16'd5, 0, 3, 14, 0, 2'b00, 8'h00, 16'h0000, 0, 0, 0));
    @(posedge clk);
    #1;
    check("post_reset_r3", rs, 16'h0000);
    check("post_reset_r14", rt, 16'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  function automatic logic [2:0] S_DONE_F();
    return 3'b111;
  endfunction

endmodule

// File: doc/thread_regfile.md
# thread_regfile

Per-thread register file for one SIMT lane of a compute core. It sits directly upstream of the lane's integer ALU and FMA unit, supplying their `rs`/`rt` operands, and it is also their write-back target. It holds 13 general-purpose registers plus three read-only special registers (block index, block size, thread index), all sequenced by the core's `core_state`.

## Interface
Parameters:
- `DATA_BITS`, 16, register and operand width.
- `THREADS_PER_BLOCK`, 4, reset and constant value of R14 (`%blockDim`).
- `THREAD_ID`, 0, reset and constant value of R15 (`%threadIdx`).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low. Asserting it (0) clears state immediately.
- `enable` in 1: lane active. When 0, all state holds.
- `block_id` in DATA_BITS: current block index, loaded into R13.
- `core_state` in 3: IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111.
- `decoded_rd_address` in 4: destination register.
- `decoded_rs_address` in 4: first source register.
- `decoded_rt_address` in 4: second source register.
- `decoded_reg_write_enable` in 1: write back this instruction.
- `decoded_reg_input_mux` in 2: write-back source. 00 = ALU, 01 = LSU, 10 = immediate, 11 = FMA.
- `decoded_immediate` in 8: CONST immediate.
- `alu_out` in DATA_BITS: integer ALU result.
- `lsu_out` in DATA_BITS: load data.
- `fma_out` in DATA_BITS: Q1.15 FMA result, written as a raw bit pattern.
- `rs` out DATA_BITS: registered operand 1.
- `rt` out DATA_BITS: registered operand 2.

## Operation
- Storage is 16 registers.
  - R0–R12 are general purpose and writable.
  - R13 = `%blockIdx`, R14 = `%blockDim`, R15 = `%threadIdx`. These are never written by instructions.
- Reset (`reset`=0, asynchronous):
  - R0–R12 = 0.
  - R13 = 0.
  - R14 = THREADS_PER_BLOCK.
  - R15 = THREAD_ID.
  - `rs` = 0, `rt` = 0.
  - Deassertion is sampled synchronously. The first update happens on the first rising edge with `reset`=1.
- All actions below require `enable`=1. With `enable`=0 nothing changes, including R13.
- IDLE: R13 <= `block_id`. R13 holds in every other state.
- REQUEST:
  - `rs` <= reg[`decoded_rs_address`].
  - `rt` <= reg[`decoded_rt_address`].
  - Any address 0–15 is readable.
- UPDATE, when `decoded_reg_write_enable`=1 and `decoded_rd_address` <= 12: reg[rd] <= selected source.
  - 00: `alu_out`.
  - 01: `lsu_out`.
  - 10: `{(DATA_BITS-8)'b0, decoded_immediate}` (zero-extended).
  - 11: `fma_out`.
- A write to rd 13–15 is silently dropped. No state changes and no error is raised.
- No other state writes or reads the file. `rs`/`rt` hold their values outside REQUEST.
- REQUEST and UPDATE never coincide, so there is no read/write hazard and no forwarding.

## Timing
- Read latency is 1 cycle. `rs`/`rt` are valid the cycle after the REQUEST edge and stable through WAIT and EXECUTE.
- Write latency is 1 cycle. The written value is visible to the next instruction's REQUEST read.
- The R13 load takes effect the edge after IDLE is sampled, and holds until the next IDLE.
- Reset mid-instruction (any state) immediately forces the reset values. Pending writes are lost.
- `enable` deasserted during UPDATE: the write is not performed.
- `enable` deasserted during REQUEST: `rs`/`rt` keep their previous values.

## Test plan
- Reset: drive `reset`=0 mid-cycle → `rs`=`rt`=0 immediately. After release, a REQUEST read of R14/R15 with THREADS_PER_BLOCK=4, THREAD_ID=2 → `rs`=4, `rt`=2.
- ALU write-back: UPDATE with rd=3, mux=00, `alu_out`=0x1234, then REQUEST rs=3 → `rs`=0x1234 one cycle after REQUEST.
- Immediate and FMA paths:
  - CONST imm=0xAB to R5 → reads 0x00AB.
  - mux=11 with `fma_out`=0x8000 to R6 → reads 0x8000.
- Protected registers:
  - UPDATE rd=15, `alu_out`=0xFFFF → R15 still reads THREAD_ID.
  - rd=13 → R13 still reads the `block_id` loaded in IDLE (e.g. 7).
- Enable gating: `enable`=0 during UPDATE rd=1 with value 0x55 → R1 unchanged. `enable`=0 during REQUEST → `rs`/`rt` hold their prior values.
- Block index: `block_id`=9 in IDLE → R13=9. Changing `block_id` to 3 in EXECUTE → R13 remains 9.
